image_stream_tx: RTL

IMAGE_STREAM_TX -- requirements
Module: image_stream_tx

---
 rtl/image_stream_tx.sv | 137 +++++++++++++
 1 files changed

// File: rtl/image_stream_tx.sv
// image_stream_tx
//   Holds one 8-bit frame in an on-chip memory and streams it to a downstream
//   filter in row-major order. The transfer runs through these phases: a load
//   phase, a wait for the filter's finish flag, a process phase that is held
//   until the host releases it, and a one-cycle flush.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   wr_en/addr/data host byte writes into frame memory (accepted in IDLE only)
//   Width, Depth    frame size in columns and rows, sampled on an accepted start
//   start           single-cycle request to transmit the frame
//   release_req     ends the processing phase. The name "release" is a
//                   reserved word in SystemVerilog, so it cannot be used here.
//   rx_finish       finish flag returned by the downstream filter
//   tx_enable       filter load enable
//   tx_pixel        filter pixel input
//   tx_process      filter process enable
//   busy            high whenever the FSM is not in IDLE
//   done            one-cycle pulse on return to IDLE
//   error           sticky fault flag (bad size or finish timeout)
//
// All outputs are registered. They are computed from the next state, so each
// output lines up with the state it describes.
module image_stream_tx #(
  parameter int MAX_IMG_WIDTH  = 500,
  parameter int MAX_IMG_HEIGHT = 500,
  parameter int ADDR_W         = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [31:0]       Width,
  input  logic [31:0]       Depth,
  input  logic              start,
  input  logic              release_req,
  input  logic              rx_finish,
  output logic              tx_enable,
  output logic [7:0]        tx_pixel,
  output logic              tx_process,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int MEM_DEPTH = MAX_IMG_WIDTH * MAX_IMG_HEIGHT;
  localparam logic [2:0] WAIT_LAST = 3'd3;  // fourth cycle spent in WAIT_FIN

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFETCH,
    S_LOAD,
    S_WAIT_FIN,
    S_PROCESS,
    S_FLUSH
  } state_t;

  state_t state_q, state_d;

  logic [7:0]        mem [0:MEM_DEPTH-1];
  logic [31:0]       n_q;        // pixels in the current frame
  logic [31:0]       pix_cnt_q;  // LOAD cycle index
  logic [2:0]        wait_cnt_q; // WAIT_FIN cycle index
  logic [ADDR_W-1:0] rd_addr_q;  // one ahead of the pixel on tx_pixel

  logic dims_ok, start_ok, start_bad, load_last, wait_tmo, rd_adv;

  always_comb begin
    dims_ok   = (Width != 32'd0) && (Depth != 32'd0) &&
                (Width <= 32'(MAX_IMG_WIDTH)) && (Depth <= 32'(MAX_IMG_HEIGHT));
    start_ok  = (state_q == S_IDLE) && start && dims_ok;
    start_bad = (state_q == S_IDLE) && start && !dims_ok;
    load_last = (pix_cnt_q == n_q - 32'd1);
    wait_tmo  = (state_q == S_WAIT_FIN) && !rx_finish && (wait_cnt_q == WAIT_LAST);
    // Stop advancing at the last pixel so the address never runs past the frame.
    rd_adv    = ((state_q == S_PREFETCH) || (state_q == S_LOAD)) &&
                (32'(rd_addr_q) < n_q - 32'd1);

    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start_ok) state_d = S_PREFETCH;
      S_PREFETCH: state_d = S_LOAD;
      S_LOAD:     if (load_last) state_d = S_WAIT_FIN;
      S_WAIT_FIN: begin
        if (rx_finish)     state_d = S_PROCESS;
        else if (wait_tmo) state_d = S_FLUSH;
      end
      S_PROCESS:  if (release_req) state_d = S_FLUSH;
      S_FLUSH:    state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // The frame memory has no reset, so its contents survive an aborted transfer.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == S_IDLE) && wr_en && (32'(wr_addr) < 32'(MEM_DEPTH)))
      mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      pix_cnt_q  <= '0;
      wait_cnt_q <= '0;
      rd_addr_q  <= '0;
      tx_enable  <= 1'b0;
      tx_pixel   <= 8'd0;
      tx_process <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy       <= (state_d != S_IDLE);
      tx_enable  <= (state_d == S_LOAD) || (state_d == S_WAIT_FIN);
      tx_process <= (state_d == S_PROCESS);
      // This is a synchronous read at the current address, which is one
      // ahead of the pixel being presented.
      tx_pixel   <= (state_d == S_LOAD) ? mem[rd_addr_q] : 8'd0;
      done       <= start_bad || (state_q == S_FLUSH);

      if (start_ok)                   error <= 1'b0;
      else if (start_bad || wait_tmo) error <= 1'b1;

      if (start_ok) n_q <= Width * Depth;

      pix_cnt_q  <= (state_q == S_LOAD)     ? pix_cnt_q + 32'd1 : 32'd0;
      wait_cnt_q <= (state_q == S_WAIT_FIN) ? wait_cnt_q + 3'd1 : 3'd0;

      if (start_ok)    rd_addr_q <= '0;
      else if (rd_adv) rd_addr_q <= rd_addr_q + 1'b1;
    end
  end

endmodule
